// File: rtl/gsim_pkg.sv
// Shared constants and state encoding for the GSIM host driver/checker.
package gsim_pkg;

  localparam int N      = 16;
  localparam int Q_FRAC = 16;
  localparam int RES_W  = 40;

  localparam int C0 = 20;
  localparam int C1 = 13;
  localparam int C2 = 6;
  localparam int C3 = 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEND    = 3'd1,
    S_WAIT    = 3'd2,
    S_COLLECT = 3'd3,
    S_CHECK   = 3'd4,
    S_REPORT  = 3'd5
  } state_t;

endpackage

// File: rtl/gsim_residual.sv
// Two-stage residual pipeline for one row of the 7-band matrix:
// |20x0 - 13(x-1+x+1) + 6(x-2+x+2) - (x-3+x+3) - (b<<<16)|, shift-add only.
module gsim_residual
  import gsim_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_vld,
  input  logic [31:0]      i_xm3,
  input  logic [31:0]      i_xm2,
  input  logic [31:0]      i_xm1,
  input  logic [31:0]      i_x0,
  input  logic [31:0]      i_xp1,
  input  logic [31:0]      i_xp2,
  input  logic [31:0]      i_xp3,
  input  logic [15:0]      i_b,
  output logic             o_vld,
  output logic [RES_W-1:0] o_abs
);

  function automatic logic signed [RES_W-1:0] sext32(input logic [31:0] v);
    return RES_W'(signed'(v));
  endfunction

  function automatic logic [RES_W-1:0] abs_res(input logic signed [RES_W-1:0] v);
    return v[RES_W-1] ? RES_W'(-v) : RES_W'(v);
  endfunction

  logic signed [RES_W-1:0] w_x0;
  logic signed [RES_W-1:0] w_s1;
  logic signed [RES_W-1:0] w_s2;
  logic signed [RES_W-1:0] w_s3;
  logic signed [RES_W-1:0] w_bq;
  logic signed [RES_W-1:0] w_sum;

  logic signed [RES_W-1:0] r_t0_p1;
  logic signed [RES_W-1:0] r_t1_p1;
  logic signed [RES_W-1:0] r_t2_p1;
  logic signed [RES_W-1:0] r_t3_p1;
  logic signed [RES_W-1:0] r_b_p1;
  logic                    r_vld_p1;
  logic [RES_W-1:0]        r_abs_p2;
  logic                    r_vld_p2;

  assign w_x0 = sext32(i_x0);
  assign w_s1 = sext32(i_xm1) + sext32(i_xp1);
  assign w_s2 = sext32(i_xm2) + sext32(i_xp2);
  assign w_s3 = sext32(i_xm3) + sext32(i_xp3);
  assign w_bq = RES_W'(signed'(i_b)) <<< Q_FRAC;

  // Stage 1: pair sums scaled by the band coefficients (20 = 16+4, 13 = 8+4+1, 6 = 4+2)
  always_ff @(posedge clk) begin
    r_t0_p1 <= (w_x0 <<< 4) + (w_x0 <<< 2);
    r_t1_p1 <= (w_s1 <<< 3) + (w_s1 <<< 2) + w_s1;
    r_t2_p1 <= (w_s2 <<< 2) + (w_s2 <<< 1);
    r_t3_p1 <= w_s3;
    r_b_p1  <= w_bq;
  end

  assign w_sum = r_t0_p1 - r_t1_p1 + r_t2_p1 - r_t3_p1 - r_b_p1;

  // Stage 2: final sum and magnitude
  always_ff @(posedge clk) begin
    r_abs_p2 <= abs_res(w_sum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_vld_p1 <= i_vld;
      r_vld_p2 <= r_vld_p1;
    end
  end

  assign o_vld = r_vld_p2;
  assign o_abs = r_abs_p2;

endmodule

// File: rtl/gsim_host.sv
// Host side of the GSIM solver: streams b out, captures x back and checks
// every row residual against TOL, reporting pass, error count and max residual.
module gsim_host
  import gsim_pkg::*;
#(
  parameter logic [31:0] TOL     = 32'h0000_0100,
  parameter int          TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_en,
  input  logic [3:0]  ld_idx,
  input  logic [15:0] ld_data,
  input  logic        start,
  output logic        in_en,
  output logic [15:0] b_in,
  input  logic        out_valid,
  input  logic [31:0] x_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_cnt,
  output logic [31:0] max_res,
  output logic        timeout
);

  state_t      r_state;
  logic [3:0]  r_k;
  logic [3:0]  r_idx;
  logic [4:0]  r_cnt;
  logic [15:0] r_tcnt;
  logic [15:0] r_b [N];
  logic [31:0] r_x [N];

  logic [15:0]      w_b0;
  logic             w_issue;
  logic [31:0]      w_tap [7];
  logic             w_res_vld;
  logic [RES_W-1:0] w_res_abs;
  logic [31:0]      w_res_sat;

  function automatic logic [31:0] sat32(input logic [RES_W-1:0] a);
    return (a > RES_W'(32'h7FFF_FFFF)) ? 32'h7FFF_FFFF : a[31:0];
  endfunction

  // Neighbour x_j for row i; rows near the ends see zeros outside 0..N-1.
  function automatic logic [31:0] tap_sel(input logic [3:0] row, input int off);
    int j;
    j = int'(row) + off - 3;
    if (j < 0 || j > N - 1) return '0;
    return r_x[j[3:0]];
  endfunction

  // A load in the same cycle as start must reach the first SEND word.
  assign w_b0    = (ld_en && ld_idx == 4'd0) ? ld_data : r_b[0];
  assign w_issue = (r_state == S_CHECK) && !r_cnt[4];

  always_comb begin
    for (int t = 0; t < 7; t++) begin
      w_tap[t] = tap_sel(r_cnt[3:0], t);
    end
  end

  always_ff @(posedge clk) begin
    if (ld_en && r_state == S_IDLE) r_b[ld_idx] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (out_valid && r_state == S_WAIT)    r_x[0]     <= x_out;
    if (out_valid && r_state == S_COLLECT) r_x[r_idx] <= x_out;
  end

  gsim_residual u_res (
    .clk   (clk),
    .rst_n (reset),
    .i_vld (w_issue),
    .i_xm3 (w_tap[0]),
    .i_xm2 (w_tap[1]),
    .i_xm1 (w_tap[2]),
    .i_x0  (w_tap[3]),
    .i_xp1 (w_tap[4]),
    .i_xp2 (w_tap[5]),
    .i_xp3 (w_tap[6]),
    .i_b   (r_b[r_cnt[3:0]]),
    .o_vld (w_res_vld),
    .o_abs (w_res_abs)
  );

  assign w_res_sat = sat32(w_res_abs);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_tcnt  <= '0;
      in_en   <= 1'b0;
      b_in    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_cnt <= '0;
      max_res <= '0;
      timeout <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_res_vld) begin
        if (w_res_abs > RES_W'(TOL)) err_cnt <= err_cnt + 5'd1;
        if (w_res_sat > max_res)     max_res <= w_res_sat;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_SEND;
            r_k     <= '0;
            in_en   <= 1'b1;
            b_in    <= w_b0;
            busy    <= 1'b1;
            pass    <= 1'b0;
            err_cnt <= '0;
            max_res <= '0;
            timeout <= 1'b0;
          end
        end
        S_SEND: begin
          if (r_k == 4'd15) begin
            r_state <= S_WAIT;
            in_en   <= 1'b0;
            b_in    <= '0;
            r_tcnt  <= '0;
          end else begin
            b_in <= r_b[r_k + 4'd1];
            r_k  <= r_k + 4'd1;
          end
        end
        S_WAIT: begin
          if (out_valid) begin
            r_state <= S_COLLECT;
            r_idx   <= 4'd1;
          end else if (r_tcnt == 16'(TIMEOUT - 1)) begin
            r_state <= S_REPORT;
            timeout <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + 16'd1;
          end
        end
        S_COLLECT: begin
          if (out_valid) begin
            if (r_idx == 4'd15) begin
              r_state <= S_CHECK;
              r_cnt   <= '0;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        S_CHECK: begin
          // 16 issue cycles plus 2 to drain the residual pipeline
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd17) r_state <= S_REPORT;
        end
        S_REPORT: begin
          r_state <= S_IDLE;
          done    <= 1'b1;
          pass    <= (err_cnt == 5'd0) && !timeout;
          busy    <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
